// File: rtl/gpr_wb_ctrl.sv
// Write-back controller for the single gpr write port: ALU results go straight
// through, load results wait in a small FIFO, and pending values are forwarded.
module gpr_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [AW-1:0]    alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             mem_valid,
    input  logic [AW-1:0]    mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    output logic             mem_ready,
    output logic             regwrite,
    output logic [AW-1:0]    a3,
    output logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    q1,
    input  logic [AW-1:0]    q2,
    output logic             q1_hit,
    output logic             q2_hit,
    output logic [WIDTH-1:0] q1_data,
    output logic [WIDTH-1:0] q2_data,
    output logic             fifo_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             live_q [DEPTH];
    logic [AW-1:0]    rd_q   [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];

    logic alu_req, push, push_live, head_live, head_dead, pop;

    assign mem_ready  = (count < FULL) & ~reset;
    assign fifo_empty = (count == '0);
    assign alu_req    = alu_valid & (alu_rd != '0);
    assign push       = mem_valid & mem_ready & (mem_rd != '0);
    // A load landing on the same edge as an ALU write to its rd is the older value.
    assign push_live  = ~(alu_req & (mem_rd == alu_rd));
    assign head_live  = ~fifo_empty & live_q[rd_ptr];
    assign head_dead  = ~fifo_empty & ~live_q[rd_ptr];
    assign pop        = head_dead | (head_live & ~alu_req);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) live_q[i] <= 1'b0;
        end else begin
            // Killed entries keep their slot until they reach the head.
            for (int i = 0; i < DEPTH; i++)
                if (alu_req && rd_q[i] == alu_rd) live_q[i] <= 1'b0;
            if (pop) begin
                live_q[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
            if (push) begin
                live_q[wr_ptr] <= push_live;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage has no reset; the live bits alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr]   <= mem_rd;
            data_q[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite <= 1'b0;
            a3       <= '0;
            wd       <= '0;
        end else if (alu_req) begin
            regwrite <= 1'b1;
            a3       <= alu_rd;
            wd       <= alu_data;
        end else if (head_live) begin
            regwrite <= 1'b1;
            a3       <= rd_q[rd_ptr];
            wd       <= data_q[rd_ptr];
        end else begin
            regwrite <= 1'b0;
        end
    end

    // Youngest live FIFO entry wins over the value currently on the write port.
    function automatic logic [WIDTH:0] lookup(input logic [AW-1:0] q);
        logic [WIDTH:0] res;
        logic [PW-1:0]  idx;
        res = '0;
        if (q != '0) begin
            if (regwrite && a3 == q) res = {1'b1, wd};
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr + PW'(k);
                if (CW'(k) < count && live_q[idx] && rd_q[idx] == q)
                    res = {1'b1, data_q[idx]};
            end
        end
        return res;
    endfunction

    assign {q1_hit, q1_data} = lookup(q1);
    assign {q2_hit, q2_data} = lookup(q2);

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Bench for gpr_wb_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based write-back model.
module tb_gpr_wb_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd, q1, q2;
    logic [31:0] alu_data, mem_data;
    logic        mem_ready, regwrite, q1_hit, q2_hit, fifo_empty;
    logic [4:0]  a3;
    logic [31:0] wd, q1_data, q2_data;

    always #5 clk = ~clk;

    gpr_wb_ctrl #(.DEPTH(DEPTH), .WIDTH(32), .AW(5)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .mem_ready(mem_ready), .regwrite(regwrite), .a3(a3), .wd(wd),
        .q1(q1), .q2(q2), .q1_hit(q1_hit), .q2_hit(q2_hit),
        .q1_data(q1_data), .q2_data(q2_data), .fifo_empty(fifo_empty)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the FIFO as a queue of results, plus the write-port registers.
    typedef struct {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_rw;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] gpr_sim [32];

    task automatic model_reset();
        mq.delete();
        m_rw = 1'b0;
        m_a3 = '0;
        m_wd = '0;
    endtask

    task automatic model_update();
        logic areq, acc, hdead;
        ent_t e;
        if (reset) begin
            model_reset();
            return;
        end
        areq  = alu_valid && alu_rd != 0;
        acc   = mem_valid && mq.size() < DEPTH;
        hdead = mq.size() > 0 && !mq[0].live;
        if (areq) begin
            m_rw = 1'b1; m_a3 = alu_rd; m_wd = alu_data;
        end else if (mq.size() > 0 && mq[0].live) begin
            m_rw = 1'b1; m_a3 = mq[0].rd; m_wd = mq[0].data;
            void'(mq.pop_front());
        end else begin
            m_rw = 1'b0;
        end
        if (hdead) void'(mq.pop_front());
        if (areq)
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].rd == alu_rd) begin
                    e = mq[i]; e.live = 1'b0; mq[i] = e;
                end
        if (acc && mem_rd != 0) begin
            e.live = !(areq && mem_rd == alu_rd);
            e.rd   = mem_rd;
            e.data = mem_data;
            mq.push_back(e);
        end
    endtask

    task automatic fwd(input logic [4:0] q, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (q == 0) return;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].live && mq[i].rd == q) begin
                hit = 1'b1; d = mq[i].data;
                return;
            end
        if (m_rw && m_a3 == q) begin
            hit = 1'b1; d = m_wd;
        end
    endtask

    task automatic compare_model();
        logic        h;
        logic [31:0] d;
        check("mem_ready", mem_ready, (mq.size() < DEPTH) && !reset);
        check("fifo_empty", fifo_empty, mq.size() == 0);
        check("regwrite", regwrite, m_rw);
        check("a3", a3, m_a3);
        check("wd", wd, m_wd);
        fwd(q1, h, d);
        check("q1_hit", q1_hit, h);
        check("q1_data", q1_data, d);
        fwd(q2, h, d);
        check("q2_hit", q2_hit, h);
        check("q2_data", q2_data, d);
    endtask

    // One clock: compare before the edge, advance model and gpr image at the edge.
    task automatic step();
        logic        prw;
        logic [4:0]  pa;
        logic [31:0] pw;
        #1;
        compare_model();
        prw = regwrite; pa = a3; pw = wd;
        @(posedge clk);
        model_update();
        if (prw) gpr_sim[pa] = pw;
        @(negedge clk);
    endtask

    task automatic idle();
        alu_valid = 0; mem_valid = 0;
        alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) gpr_sim[i] = '0;
        reset = 1'b1;
        idle();
        q1 = 0; q2 = 0;
        model_reset();
        #1;
        check("rst_regwrite", regwrite, 1'b0);
        check("rst_a3", a3, 5'd0);
        check("rst_wd", wd, 32'd0);
        check("rst_fifo_empty", fifo_empty, 1'b1);
        check("rst_mem_ready", mem_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_mem_ready", mem_ready, 1'b1);

        // Plain ALU write and forward of it.
        alu_valid = 1; alu_rd = 8; alu_data = 32'hAAAAAAAA;
        step();
        idle();
        check("alu_regwrite", regwrite, 1'b1);
        check("alu_a3", a3, 5'd8);
        check("alu_wd", wd, 32'hAAAAAAAA);
        q1 = 8;
        #1;
        check("alu_fwd_hit", q1_hit, 1'b1);
        check("alu_fwd_data", q1_data, 32'hAAAAAAAA);
        step();
        check("gpr_r8", gpr_sim[8], 32'hAAAAAAAA);
        q1 = 0;

        // Four loads stalled behind six ALU cycles, then drained in order.
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_rd = 1; alu_data = $urandom;
            mem_valid = (i < 4); mem_rd = 5'(9 + i); mem_data = 32'(9 + i);
            step();
            check("stall_regwrite", regwrite, 1'b1);
            check("stall_a3", a3, 5'd1);
            if (i == 3) check("full_mem_ready", mem_ready, 1'b0);
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            step();
            check("drain_a3", a3, 5'(9 + k));
            check("drain_wd", wd, 32'(9 + k));
        end
        check("drain_empty", fifo_empty, 1'b1);

        // Queued load overtaken by a later ALU write to the same register.
        mem_valid = 1; mem_rd = 5; mem_data = 32'h11;
        step();
        idle();
        alu_valid = 1; alu_rd = 5; alu_data = 32'h22;
        step();
        idle();
        q1 = 5;
        #1;
        check("kill_fwd_hit", q1_hit, 1'b1);
        check("kill_fwd_data", q1_data, 32'h22);
        step();
        check("kill_no_write", regwrite, 1'b0);
        check("kill_empty", fifo_empty, 1'b1);
        check("gpr_r5", gpr_sim[5], 32'h22);
        q1 = 0;

        // Load and ALU to the same register on the same edge.
        mem_valid = 1; mem_rd = 6; mem_data = 32'h33;
        alu_valid = 1; alu_rd = 6; alu_data = 32'h44;
        step();
        idle();
        check("same_a3", a3, 5'd6);
        check("same_wd", wd, 32'h44);
        check("same_dead_queued", fifo_empty, 1'b0);
        step();
        check("same_no_write", regwrite, 1'b0);
        check("same_empty", fifo_empty, 1'b1);
        step();
        check("gpr_r6", gpr_sim[6], 32'h44);

        // Register 0 on both sides.
        alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
        mem_valid = 1; mem_rd = 0; mem_data = 32'hBEEF;
        q1 = 0;
        #1;
        check("r0_handshake", mem_ready, 1'b1);
        check("r0_hit", q1_hit, 1'b0);
        step();
        idle();
        check("r0_no_write", regwrite, 1'b0);
        check("r0_empty", fifo_empty, 1'b1);

        // Random traffic on a small register range to force collisions.
        for (int n = 0; n < 400; n++) begin
            alu_valid = ($urandom_range(0, 9) < 4);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            mem_valid = ($urandom_range(0, 9) < 6);
            mem_rd    = 5'($urandom_range(0, 7));
            mem_data  = $urandom;
            q1        = 5'($urandom_range(0, 7));
            q2        = 5'($urandom_range(0, 7));
            step();
        end
        idle();
        q1 = 0; q2 = 0;
        for (int n = 0; n < 6; n++) step();

        // Reset while a drain is in progress.
        for (int i = 0; i < 5; i++) begin
            alu_valid = (i < 4); alu_rd = 1; alu_data = 32'h5;
            mem_valid = (i < 4); mem_rd = 5'(13 + i); mem_data = 32'(13 + i);
            step();
        end
        idle();
        check("pre_rst_regwrite", regwrite, 1'b1);
        check("pre_rst_empty", fifo_empty, 1'b0);
        reset = 1'b1;
        model_reset();
        #1;
        check("mid_rst_empty", fifo_empty, 1'b1);
        check("mid_rst_regwrite", regwrite, 1'b0);
        check("mid_rst_a3", a3, 5'd0);
        check("mid_rst_wd", wd, 32'd0);
        check("mid_rst_mem_ready", mem_ready, 1'b0);
        step();
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            check("post_rst_no_write", regwrite, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
